// File: rtl/quad_stair_nco.sv
// rtl/quad_stair_nco.sv - quadrature staircase NCO with burst count and valid/ready output
// Optional linear chirp sweep enabled by `define NCO_CHIRP_SWEEP_EN.

module quad_stair_nco #(
   parameter int PHASE_W = 16,
   parameter int OUT_W   = 14,
   parameter int CNT_W   = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [PHASE_W-1:0] freq_init,
   input  logic [PHASE_W-1:0] freq_step,
   input  logic [PHASE_W-1:0] freq_lo,
   input  logic [PHASE_W-1:0] freq_hi,
   input  logic [CNT_W-1:0]   num_samples,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [OUT_W-1:0]   i_out,
   output logic [OUT_W-1:0]   q_out,
   output logic               busy,
   output logic               done
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state;
   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] r_freq;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_xfer;
   logic [PHASE_W-1:0] w_phase_nxt;
   logic [3:0]         w_sector_nxt;
   logic [PHASE_W-1:0] w_freq_nxt;

   // Quarter-wave magnitude folded over the 16 sectors; upper half is negated.
   function automatic logic [OUT_W-1:0] f_sin(input logic [3:0] k);
      logic [1:0]       idx;
      logic [13:0]      mag;
      logic [OUT_W-1:0] m;
      idx = k[2] ? ~k[1:0] : k[1:0];
      case (idx)
         2'd0:    mag = 14'd799;
         2'd1:    mag = 14'd2276;
         2'd2:    mag = 14'd3406;
         default: mag = 14'd4017;
      endcase
      m = OUT_W'(mag) << (OUT_W - 14);
      return k[3] ? (~m + OUT_W'(1)) : m;
   endfunction

   function automatic logic [OUT_W-1:0] f_cos(input logic [3:0] k);
      return f_sin(k + 4'd4);
   endfunction

   assign w_xfer       = out_valid & out_ready;
   assign w_phase_nxt  = r_phase + r_freq;
   assign w_sector_nxt = w_phase_nxt[PHASE_W-1 -: 4];

`ifdef NCO_CHIRP_SWEEP_EN
   localparam logic [PHASE_W-1:0] ONE = PHASE_W'(1);

   logic [PHASE_W-1:0]        r_step;
   logic [PHASE_W-1:0]        r_lo;
   logic [PHASE_W-1:0]        r_hi;
   logic signed [PHASE_W+1:0] w_sum;

   assign w_sum = $signed({2'b00, r_freq}) + $signed({{2{r_step[PHASE_W-1]}}, r_step});

   // Out-of-band sums fold back into [lo, hi] by the overshoot distance.
   always_comb begin
      w_freq_nxt = w_sum[PHASE_W-1:0];
      if (w_sum > $signed({2'b00, r_hi}))
         w_freq_nxt = r_lo + (w_sum[PHASE_W-1:0] - r_hi - ONE);
      else if (w_sum < $signed({2'b00, r_lo}))
         w_freq_nxt = r_hi - (r_lo - w_sum[PHASE_W-1:0] - ONE);
   end
`else
   logic w_unused_sweep;
   assign w_unused_sweep = ^{freq_step, freq_lo, freq_hi};
   assign w_freq_nxt     = r_freq;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_phase   <= '0;
         r_freq    <= '0;
         r_cnt     <= '0;
         out_valid <= 1'b0;
         i_out     <= '0;
         q_out     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef NCO_CHIRP_SWEEP_EN
         r_step    <= '0;
         r_lo      <= '0;
         r_hi      <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (num_samples != '0) begin
                     r_phase   <= '0;
                     r_freq    <= freq_init;
                     r_cnt     <= num_samples;
                     i_out     <= f_sin(4'd0);
                     q_out     <= f_cos(4'd0);
                     out_valid <= 1'b1;
                     busy      <= 1'b1;
                     r_state   <= S_RUN;
`ifdef NCO_CHIRP_SWEEP_EN
                     r_step    <= freq_step;
                     r_lo      <= freq_lo;
                     r_hi      <= freq_hi;
`endif
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_xfer) begin
                  r_phase <= w_phase_nxt;
                  r_freq  <= w_freq_nxt;
                  r_cnt   <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     i_out <= f_sin(w_sector_nxt);
                     q_out <= f_cos(w_sector_nxt);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_stair_nco.sv
// tb/tb_quad_stair_nco.sv - scoreboard bench for quad_stair_nco
// Sweep case is exercised only when NCO_CHIRP_SWEEP_EN is defined.

module tb_quad_stair_nco;

   localparam int PHASE_W = 16;
   localparam int OUT_W   = 14;
   localparam int CNT_W   = 12;
   localparam int SC      = 1 << (OUT_W - 14);
`ifdef NCO_CHIRP_SWEEP_EN
   localparam logic [PHASE_W-1:0] T2_STEP = 16'h0000;
   localparam int                 T2_HI   = 16'hFFFF;
`else
   localparam logic [PHASE_W-1:0] T2_STEP = 16'h1000;
   localparam int                 T2_HI   = 16'h3000;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [PHASE_W-1:0] freq_init = '0;
   logic [PHASE_W-1:0] freq_step = '0;
   logic [PHASE_W-1:0] freq_lo = '0;
   logic [PHASE_W-1:0] freq_hi = '0;
   logic [CNT_W-1:0]   num_samples = '0;
   logic               out_ready = 1'b0;
   logic               out_valid;
   logic [OUT_W-1:0]   i_out;
   logic [OUT_W-1:0]   q_out;
   logic               busy;
   logic               done;

   quad_stair_nco #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .freq_init(freq_init), .freq_step(freq_step), .freq_lo(freq_lo), .freq_hi(freq_hi),
      .num_samples(num_samples), .out_ready(out_ready), .out_valid(out_valid),
      .i_out(i_out), .q_out(q_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;
   int n_xfer = 0;
   int n_done = 0;
   int exp_i[$];
   int exp_q[$];
   int sin_tbl[16] = '{799, 2276, 3406, 4017, 4017, 3406, 2276, 799,
                       -799, -2276, -3406, -4017, -4017, -3406, -2276, -799};

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int s_out(input logic [OUT_W-1:0] v);
      return int'($signed(v));
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            n_done++;
            check("done_vs_valid", int'(out_valid), 0);
         end
         if (out_valid && out_ready) begin
            n_xfer++;
            if (exp_i.size() == 0) begin
               check("unexpected_sample", s_out(i_out), 99999);
            end else begin
               check("sample_i", s_out(i_out), exp_i.pop_front());
               check("sample_q", s_out(q_out), exp_q.pop_front());
            end
         end
      end
   end

   task automatic push_burst(input int f0, input int step, input int lo, input int hi,
                             input int n, input bit sweep);
      int ph, f, k, s, sum;
      ph = 0;
      f  = f0;
      s  = (step >= 32768) ? step - 65536 : step;
      for (int j = 0; j < n; j++) begin
         k = (ph >> (PHASE_W - 4)) & 15;
         exp_i.push_back(sin_tbl[k] * SC);
         exp_q.push_back(sin_tbl[(k + 4) % 16] * SC);
         ph = (ph + f) & 16'hFFFF;
         if (sweep) begin
            sum = f + s;
            if (sum > hi)      f = (lo + (sum - hi - 1)) & 16'hFFFF;
            else if (sum < lo) f = (hi - (lo - sum - 1)) & 16'hFFFF;
            else               f = sum;
         end
      end
   endtask

   task automatic start_burst(input int f0, input int step, input int lo, input int hi,
                              input int n);
      @(posedge clk); #1;
      freq_init   = PHASE_W'(f0);
      freq_step   = PHASE_W'(step);
      freq_lo     = PHASE_W'(lo);
      freq_hi     = PHASE_W'(hi);
      num_samples = CNT_W'(n);
      start       = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int d0, c;
      d0 = n_done;
      c  = 0;
      while (n_done == d0 && c < max_cyc) begin
         @(posedge clk); #1;
         c++;
      end
      check(tag, n_done - d0, 1);
      check({tag, "_queue"}, exp_i.size(), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int x0, d0, c;
      #12;
      check("rst_valid", int'(out_valid), 0);
      check("rst_i", s_out(i_out), 0);
      check("rst_q", s_out(q_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Plain staircase burst, one sector per sample
      out_ready = 1'b1;
      x0 = n_xfer;
      push_burst(16'h1000, T2_STEP, 16'h1000, T2_HI, 16, 1'b0);
      start_burst(16'h1000, T2_STEP, 16'h1000, T2_HI, 16);
      check("t2_first_busy", int'(busy), 1);
      wait_done("t2_done", 40);
      check("t2_xfers", n_xfer - x0, 16);
      check("t2_hold_i", s_out(i_out), sin_tbl[15] * SC);
      check("t2_hold_q", s_out(q_out), sin_tbl[3] * SC);

      // Backpressure for three cycles after the second sample
      x0 = n_xfer;
      push_burst(16'h1000, 0, 0, 16'hFFFF, 16, 1'b0);
      start_burst(16'h1000, 0, 0, 16'hFFFF, 16);
      c = 0;
      while (n_xfer < x0 + 2 && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         check("t3_stall_valid", int'(out_valid), 1);
         check("t3_stall_i", s_out(i_out), sin_tbl[2] * SC);
      end
      out_ready = 1'b1;
      wait_done("t3_done", 40);
      check("t3_xfers", n_xfer - x0, 16);

`ifdef NCO_CHIRP_SWEEP_EN
      x0 = n_xfer;
      push_burst(16'h1000, 16'h1000, 16'h1000, 16'h3000, 5, 1'b1);
      start_burst(16'h1000, 16'h1000, 16'h1000, 16'h3000, 5);
      wait_done("t4_done", 30);
      check("t4_xfers", n_xfer - x0, 5);
`endif

      // Empty burst
      @(posedge clk); #1;
      num_samples = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("t5_done_pulse", int'(done), 1);
      check("t5_no_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      check("t5_done_low", int'(done), 0);
      check("t5_idle_valid", int'(out_valid), 0);

      // Second start while running must be ignored
      out_ready = 1'b0;
      x0 = n_xfer;
      push_burst(16'h1000, 0, 0, 16'hFFFF, 4, 1'b0);
      start_burst(16'h1000, 0, 0, 16'hFFFF, 4);
      start_burst(16'h4000, 0, 0, 16'hFFFF, 9);
      out_ready = 1'b1;
      wait_done("t5_run_done", 30);
      check("t5_run_xfers", n_xfer - x0, 4);

      // Asynchronous reset in the middle of a burst
      d0 = n_done;
      push_burst(16'h1000, 0, 0, 16'hFFFF, 16, 1'b0);
      start_burst(16'h1000, 0, 0, 16'hFFFF, 16);
      repeat (5) begin
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_rst_valid", int'(out_valid), 0);
      check("t1_rst_i", s_out(i_out), 0);
      check("t1_rst_q", s_out(q_out), 0);
      check("t1_rst_busy", int'(busy), 0);
      exp_i.delete();
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
      end
      check("t1_no_done", n_done - d0, 0);
      check("t1_idle_valid", int'(out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
